// File: rtl/oht2bin_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oht2bin_pkg
// Description : Shared types and constants for the one-hot to binary encoder
//               pipeline. Optional checker macro: OHT2BIN_ONEHOT_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package oht2bin_pkg;

  // Saturation ceiling of the erroneous-transfer counter.
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  // Flag portion of the per-stage payload; the index field is sized in the
  // instantiating module because it depends on its WIDTH parameter.
  typedef struct packed {
    logic nzr;
    logic err;
  } oht2bin_flags_t;

  // Index width for a one-hot vector of the given width, never below 1 bit.
  function automatic int oht2bin_idx_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/oht2bin_base.sv
`default_nettype none
// ============================================================================
// Module      : oht2bin_base
// Description : Combinational one-hot to binary encoder. Each index bit is the
//               OR of the input bits whose position has that index bit set,
//               so multi-hot inputs yield the OR of their indices.
//               Multi-hot detection exists only with OHT2BIN_ONEHOT_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module oht2bin_base
  import oht2bin_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int WIDTH_LOG = oht2bin_idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0]     oht_i,
  output logic [WIDTH_LOG-1:0] bin_o,
  output logic                 nzr_o,
  output logic                 err_o
);

  // One OR-reduction per index bit over a constant position mask.
  for (genvar b = 0; b < WIDTH_LOG; b++) begin : g_bit
    logic [WIDTH-1:0] w_mask;
    for (genvar i = 0; i < WIDTH; i++) begin : g_mask
      assign w_mask[i] = 1'((i >> b) & 1);
    end
    assign bin_o[b] = |(oht_i & w_mask);
  end

  assign nzr_o = |oht_i;

`ifdef OHT2BIN_ONEHOT_CHECK_EN
  logic w_seen;
  logic w_multi;

  // Popcount >= 2: some set bit found after another set bit was already seen.
  always_comb begin
    w_seen  = 1'b0;
    w_multi = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      w_multi = w_multi | (w_seen & oht_i[i]);
      w_seen  = w_seen | oht_i[i];
    end
  end

  assign err_o = w_multi;
`else
  assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/oht2bin_pipe.sv
`default_nettype none
// ============================================================================
// Module      : oht2bin_pipe
// Description : Pipelined one-hot to binary index encoder on valid/ready
//               streams. STAGES=1 registers the encoded result only; STAGES=2
//               also registers the raw input vector ahead of the encoder.
//               Ready is a combinational chain, giving 1 transfer/cycle.
//               Optional checker macro: OHT2BIN_ONEHOT_CHECK_EN (m_err and
//               saturating err_cnt; both tied 0 when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module oht2bin_pipe
  import oht2bin_pkg::*;
#(
  parameter  int WIDTH     = 32,
  parameter  int STAGES    = 1,
  localparam int WIDTH_LOG = oht2bin_idx_w(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_vld,
  output logic                 s_rdy,
  input  logic [WIDTH-1:0]     s_oht,
  output logic                 m_vld,
  input  logic                 m_rdy,
  output logic [WIDTH_LOG-1:0] m_bin,
  output logic                 m_nzr,
  output logic                 m_err,
  output logic [7:0]           err_cnt
);

  typedef struct packed {
    logic [WIDTH_LOG-1:0] bin;
    oht2bin_flags_t       flags;
  } payload_t;

  logic             w_enc_vld;
  logic [WIDTH-1:0] w_enc_oht;
  logic             w_out_rdy;
  payload_t         w_out_pl_d;
  logic             out_vld_q;
  payload_t         out_pl_q;

  if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
    $fatal(1, "oht2bin_pipe: STAGES must be 1 or 2");
  end

  if (STAGES == 2) begin : g_in_reg
    logic             in_vld_q;
    logic [WIDTH-1:0] in_oht_q;

    // Input stage: capture the raw vector; payload loads only on a transfer.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        in_vld_q <= 1'b0;
        in_oht_q <= '0;
      end else if (s_rdy) begin
        in_vld_q <= s_vld;
        if (s_vld) begin
          in_oht_q <= s_oht;
        end
      end
    end

    assign s_rdy     = ~in_vld_q | w_out_rdy;
    assign w_enc_vld = in_vld_q;
    assign w_enc_oht = in_oht_q;
  end else begin : g_in_bypass
    assign s_rdy     = w_out_rdy;
    assign w_enc_vld = s_vld;
    assign w_enc_oht = s_oht;
  end

  oht2bin_base #(
    .WIDTH     (WIDTH),
    .WIDTH_LOG (WIDTH_LOG)
  ) u_base (
    .oht_i (w_enc_oht),
    .bin_o (w_out_pl_d.bin),
    .nzr_o (w_out_pl_d.flags.nzr),
    .err_o (w_out_pl_d.flags.err)
  );

  assign w_out_rdy = ~out_vld_q | m_rdy;

  // Output stage: hold while stalled, reload only when an item enters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_pl_q  <= '0;
    end else if (w_out_rdy) begin
      out_vld_q <= w_enc_vld;
      if (w_enc_vld) begin
        out_pl_q <= w_out_pl_d;
      end
    end
  end

  assign m_vld = out_vld_q;
  assign m_bin = out_pl_q.bin;
  assign m_nzr = out_pl_q.flags.nzr;
  // Constant 0 when the checker is compiled out, since the encoder drives 0.
  assign m_err = out_pl_q.flags.err;

`ifdef OHT2BIN_ONEHOT_CHECK_EN
  logic [7:0] err_cnt_q;

  // Count multi-hot items as they leave, saturating at the ceiling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (out_vld_q && m_rdy && out_pl_q.flags.err && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_oht2bin_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_oht2bin_pipe
// Description : Self-checking bench for oht2bin_pipe. Two instances run side
//               by side: index 0 with STAGES=1, index 1 with STAGES=2.
//               Checker expectations follow OHT2BIN_ONEHOT_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oht2bin_pipe;

`ifdef OHT2BIN_ONEHOT_CHECK_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] bin;
    logic       nzr;
    logic       err;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [1:0]       s_vld;
  logic [1:0]       s_rdy;
  logic [1:0][31:0] s_oht;
  logic [1:0]       m_vld;
  logic [1:0]       m_rdy;
  logic [1:0][4:0]  m_bin;
  logic [1:0]       m_nzr;
  logic [1:0]       m_err;
  logic [1:0][7:0]  err_cnt;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    oht2bin_pipe #(
      .WIDTH  (32),
      .STAGES (k + 1)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .s_vld   (s_vld[k]),
      .s_rdy   (s_rdy[k]),
      .s_oht   (s_oht[k]),
      .m_vld   (m_vld[k]),
      .m_rdy   (m_rdy[k]),
      .m_bin   (m_bin[k]),
      .m_nzr   (m_nzr[k]),
      .m_err   (m_err[k]),
      .err_cnt (err_cnt[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb [2][$];
  int   exp_cnt [2];
  bit   acc [2];
  int   n_in [2];
  int   n_out [2];

  // Reference: index = OR of all set positions, nzr = any bit, err = 2+ bits.
  function automatic exp_t model(input logic [31:0] v);
    exp_t        e;
    int unsigned idx_or;
    idx_or = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx_or = idx_or | i;
    end
    e.bin = idx_or[4:0];
    e.nzr = (v != 0);
    e.err = FEAT && ($countones(v) >= 2);
    return e;
  endfunction

  function automatic logic [31:0] rand_vec();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'h0;
    if (r == 1) return $urandom();
    return 32'h1 << $urandom_range(0, 31);
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  // Evaluate the handshakes that will complete at the coming rising edge.
  task automatic monitor();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      chk("err_cnt", k, {24'h0, err_cnt[k]}, exp_cnt[k]);
      if (m_vld[k] && m_rdy[k]) begin
        chk("sb_nonempty", k, {31'h0, sb[k].size() != 0}, 32'h1);
        if (sb[k].size() != 0) begin
          e = sb[k].pop_front();
          chk("m_bin", k, {27'h0, m_bin[k]}, {27'h0, e.bin});
          chk("m_nzr", k, {31'h0, m_nzr[k]}, {31'h0, e.nzr});
          chk("m_err", k, {31'h0, m_err[k]}, {31'h0, e.err});
          if (e.err && exp_cnt[k] < 255) exp_cnt[k]++;
          n_out[k]++;
        end
      end
      if (s_vld[k] && s_rdy[k]) begin
        sb[k].push_back(model(s_oht[k]));
        acc[k] = 1'b1;
        n_in[k]++;
      end else begin
        acc[k] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_in [2];
    int base_out;
    int cyc;

    rst   = 1'b1;
    s_vld = '0;
    s_oht = '0;
    m_rdy = '0;
    for (int k = 0; k < 2; k++) begin
      exp_cnt[k] = 0;
      acc[k]     = 1'b0;
      n_in[k]    = 0;
      n_out[k]   = 0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_m_vld", k, {31'h0, m_vld[k]}, 32'h0);
      chk("rst_m_bin", k, {27'h0, m_bin[k]}, 32'h0);
      chk("rst_m_nzr", k, {31'h0, m_nzr[k]}, 32'h0);
      chk("rst_m_err", k, {31'h0, m_err[k]}, 32'h0);
      chk("rst_err_cnt", k, {24'h0, err_cnt[k]}, 32'h0);
      chk("rst_s_rdy", k, {31'h0, s_rdy[k]}, 32'h1);
    end
    rst = 1'b0;
    tick();

    // Single transfer, STAGES=1: 1-cycle latency
    m_rdy    = 2'b11;
    s_vld[0] = 1'b1;
    s_oht[0] = 32'h0000_0100;
    tick();
    chk("single_m_vld", 0, {31'h0, m_vld[0]}, 32'h1);
    chk("single_m_bin", 0, {27'h0, m_bin[0]}, 32'd8);
    chk("single_m_nzr", 0, {31'h0, m_nzr[0]}, 32'h1);
    chk("single_m_err", 0, {31'h0, m_err[0]}, 32'h0);

    // Zero vector still transfers
    s_oht[0] = 32'h0;
    tick();
    s_vld[0] = 1'b0;
    chk("zero_m_vld", 0, {31'h0, m_vld[0]}, 32'h1);
    chk("zero_m_bin", 0, {27'h0, m_bin[0]}, 32'h0);
    chk("zero_m_nzr", 0, {31'h0, m_nzr[0]}, 32'h0);
    tick();
    chk("zero_drained", 0, {31'h0, m_vld[0]}, 32'h0);
    chk("zero_sb_empty", 0, sb[0].size(), 32'h0);

    // Backpressure, STAGES=2: indices 0, 1, 31 with m_rdy low
    base_out = n_out[1];
    m_rdy[1] = 1'b0;
    s_vld[1] = 1'b1;
    s_oht[1] = 32'h0000_0001;
    tick();
    s_oht[1] = 32'h0000_0002;
    tick();
    s_oht[1] = 32'h8000_0000;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_s_rdy", 1, {31'h0, s_rdy[1]}, 32'h0);
      chk("bp_m_vld", 1, {31'h0, m_vld[1]}, 32'h1);
      chk("bp_hold_bin", 1, {27'h0, m_bin[1]}, 32'h0);
      chk("bp_hold_nzr", 1, {31'h0, m_nzr[1]}, 32'h1);
    end
    m_rdy[1] = 1'b1;
    for (int c = 0; c < 10 && s_vld[1]; c++) begin
      tick();
      if (acc[1]) s_vld[1] = 1'b0;
    end
    repeat (4) tick();
    chk("bp_delivered", 1, n_out[1] - base_out, 32'd3);
    chk("bp_sb_empty", 1, sb[1].size(), 32'h0);

    // Multi-hot, then saturate the error counter
    s_vld[0] = 1'b1;
    s_oht[0] = 32'h0000_0006;
    tick();
    s_vld[0] = 1'b0;
    chk("multi_m_bin", 0, {27'h0, m_bin[0]}, 32'd3);
    chk("multi_m_nzr", 0, {31'h0, m_nzr[0]}, 32'h1);
    chk("multi_m_err", 0, {31'h0, m_err[0]}, {31'h0, FEAT});
    tick();
    chk("multi_err_cnt1", 0, {24'h0, err_cnt[0]}, FEAT ? 32'd1 : 32'd0);
    s_vld[0] = 1'b1;
    repeat (300) tick();
    s_vld[0] = 1'b0;
    repeat (2) tick();
    chk("multi_err_cnt_sat", 0, {24'h0, err_cnt[0]}, FEAT ? 32'd255 : 32'd0);

    // Asynchronous reset between edges while outputs are valid
    m_rdy = 2'b00;
    s_vld = 2'b11;
    s_oht[0] = 32'h0000_0020;
    s_oht[1] = 32'h0000_0020;
    tick();
    s_vld = 2'b00;
    tick();
    chk("pre_rst_m_vld", 0, {31'h0, m_vld[0]}, 32'h1);
    chk("pre_rst_m_vld", 1, {31'h0, m_vld[1]}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("arst_m_vld", k, {31'h0, m_vld[k]}, 32'h0);
      chk("arst_err_cnt", k, {24'h0, err_cnt[k]}, 32'h0);
      sb[k].delete();
      exp_cnt[k] = 0;
    end
    rst = 1'b0;
    #0;
    for (int k = 0; k < 2; k++) chk("arst_s_rdy", k, {31'h0, s_rdy[k]}, 32'h1);
    m_rdy = 2'b11;
    tick();

    // Random sweep: 1000 transfers per instance with random backpressure
    for (int k = 0; k < 2; k++) base_in[k] = n_in[k];
    cyc = 0;
    while ((n_in[0] - base_in[0] < 1000 || n_in[1] - base_in[1] < 1000) && cyc < 20000) begin
      for (int k = 0; k < 2; k++) begin
        if (!s_vld[k] || acc[k]) begin
          s_vld[k] = (n_in[k] - base_in[k] < 1000) && ($urandom_range(0, 3) != 0);
          s_oht[k] = rand_vec();
        end
        m_rdy[k] = ($urandom_range(0, 3) != 0);
      end
      tick();
      cyc++;
    end
    for (int k = 0; k < 2; k++) chk("sweep_done", k, {31'h0, n_in[k] - base_in[k] >= 1000}, 32'h1);

    // Drain, then full throughput with m_rdy held high
    s_vld = 2'b00;
    m_rdy = 2'b11;
    repeat (4) tick();
    for (int k = 0; k < 2; k++) base_in[k] = n_in[k];
    s_vld = 2'b11;
    for (int c = 0; c < 50; c++) begin
      s_oht[0] = rand_vec();
      s_oht[1] = rand_vec();
      tick();
    end
    s_vld = 2'b00;
    for (int k = 0; k < 2; k++) chk("throughput", k, n_in[k] - base_in[k], 32'd50);
    repeat (4) tick();
    for (int k = 0; k < 2; k++) chk("final_sb_empty", k, sb[k].size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/oht2bin_pipe.md
Name: oht2bin_pipe

Overview:
- Pipelined one-hot to binary index encoder. It is the reverse of the priority to one-hot converter.
- Accepts a one-hot vector on a valid/ready stream and emits the bit index plus a non-zero flag on an output stream.
- Sits downstream of arbiters and priority converters, and turns grant vectors into mux selects and FIFO tags.
- Registered stages break the wide OR-tree for timing.

Parameters:
- WIDTH, 32, one-hot vector width, >=2.
- WIDTH_LOG, $clog2(WIDTH), local parameter, index width.
- STAGES, 1, pipeline depth: 1 = output register only; 2 = input register plus output register. Other values cause $fatal at elaboration.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- s_vld  input  1  input stream valid
- s_rdy  output  1  input stream ready
- s_oht  input  WIDTH  one-hot input vector
- m_vld  output  1  output stream valid
- m_rdy  input  1  output stream ready
- m_bin  output  WIDTH_LOG  encoded index
- m_nzr  output  1  input vector was non-zero
- m_err  output  1  input had more than one bit set (feature only; tied 0 otherwise)
- err_cnt  output  8  saturating count of erroneous transfers (feature only; tied 0 otherwise)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high on rst. While rst=1, all state clears immediately, independent of clk.
- Reset values: m_vld=0, m_bin=0, m_nzr=0, m_err=0, err_cnt=0, internal stage valid=0. s_rdy after reset is 1, since the pipeline is empty.
- Transfers: a transfer occurs on a rising clk edge when vld&rdy on that interface.
- Handshake per stage: stage ready = ~stage_vld | downstream_ready.
  - This is a combinational ready chain; no bubbles; full throughput of 1 transfer/cycle.
  - s_rdy equals first-stage ready.
- Latency: STAGES cycles from the input transfer to m_vld, given no backpressure.
- Output hold: while m_vld=1 and m_rdy=0, m_bin, m_nzr and m_err hold stable. Payload registers load only on a stage transfer.
- Encoding: m_bin = bitwise OR over i of (i if s_oht[i]), computed per output bit as the OR of s_oht[i] where bit b of i is set.
  - Zero input: m_bin=0, m_nzr=0. The transfer still occurs; it is not dropped.
  - Multi-hot input: m_bin = OR of the set indices (defined, not X), m_nzr=1.
- STAGES=2: stage 1 registers the raw s_oht and s_vld; stage 2 registers the encoded result.
- Simultaneous events: a new input is accepted in the same cycle the output transfers out when full, because ready propagates from m_rdy.
- Reset mid-operation: in-flight data is discarded, not flushed.
- X handling: s_oht is ignored (registers are not loaded) when s_vld=0.

Optional Feature:
- Macro: OHT2BIN_ONEHOT_CHECK_EN.
- With the macro defined:
  - m_err = 1 when the accepted vector has popcount >=2, computed in parallel with the encoder and pipelined alongside m_bin.
  - err_cnt increments by 1 on each output transfer with m_err=1 and saturates at 255.
  - err_cnt clears only on reset.
- Without the macro: m_err and err_cnt are constant 0, and no checker logic is synthesized.

Decomposition:
- Package oht2bin_pkg:
  - function clog2-safe index width helper.
  - typedef struct packed {bin, nzr, err} for the stage payload, parameterized through a localparam width in the module.
  - Constant ERR_CNT_MAX=8'hFF.
- Sub-module oht2bin_base: purely combinational one-hot to binary encoder with outputs bin, nzr, err. It is instantiated once in the encode stage.
- The module itself holds only the pipeline registers and the handshake.

Test Plan:
- Reset then single transfer: WIDTH=32, STAGES=1, s_oht=32'h0000_0100, m_rdy=1 -> after 1 cycle m_vld=1, m_bin=8, m_nzr=1, m_err=0.
- Zero vector: s_oht=0 -> m_vld=1, m_bin=0, m_nzr=0; the transfer is consumed, not dropped.
- Backpressure, STAGES=2:
  - Stream 5'd0,1,31 one-hots with m_rdy=0 for 3 cycles -> s_rdy=0 after 2 accepted transfers; outputs held stable.
  - Release m_rdy -> indices 0,1,31 delivered in order with no loss or duplicate.
- Multi-hot with feature defined: s_oht=32'h0000_0006 -> m_bin=3, m_err=1, err_cnt=1. After 300 such transfers, err_cnt=255.
- Async reset mid-stream: assert rst between clock edges while m_vld=1 -> m_vld=0, err_cnt=0 immediately, before the next edge. After release, s_rdy=1.
- Full-throughput sweep: random one-hots, 1000 transfers, random m_rdy -> scoreboard matches $clog2-style index for every transfer. Throughput is 1/cycle when m_rdy is held at 1.
